// File: rtl/timer_irq_master_pkg.sv
// Shared state encoding, timer register map and control words for timer_irq_master.
// SNAP_* states exist only when TIMER_IRQ_MASTER_SNAP_EN is defined.
package timer_irq_master_pkg;

`ifdef TIMER_IRQ_MASTER_SNAP_EN
    typedef enum logic [3:0] {
        IDLE, CFG_WR, RUN, CLR_WR, CLR_WAIT, STOP_WR, SNAP_WR, SNAP_RDL, SNAP_RDH
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, CFG_WR, RUN, CLR_WR, CLR_WAIT, STOP_WR
    } state_t;
`endif

    localparam int unsigned REG_STATUS  = 0;
    localparam int unsigned REG_CONTROL = 1;
    localparam int unsigned REG_SNAP_L  = 4;
    localparam int unsigned REG_SNAP_H  = 5;

    // ITO | CONT | START
    localparam int unsigned CTRL_START  = 32'h0007;
    localparam int unsigned CTRL_STOP   = 32'h0008;

endpackage

// File: rtl/avmm_cmd_issuer.sv
// Avalon-MM command holder: drives one write/read command until sampled with waitrequest low.
// Latency: accept is combinational; read data valid READ_LATENCY cycles after acceptance.
// Backpressure: command held stable under av_waitrequest; bus idles while a read return is pending.
module avmm_cmd_issuer #(
    parameter int ADDR_W       = 3,
    parameter int DATA_W       = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_vld,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_dat,
    output logic              cmd_acc,
    output logic              rd_vld,
    output logic [DATA_W-1:0] rd_dat,
    output logic              busy,
    output logic [ADDR_W-1:0] av_address,
    output logic              av_chipselect,
    output logic              av_write_n,
    output logic              av_read_n,
    output logic [DATA_W-1:0] av_writedata,
    input  logic [DATA_W-1:0] av_readdata,
    input  logic              av_waitrequest
);

    localparam int CNT_W = 3;

    logic             rd_pend;
    logic [CNT_W-1:0] rd_cnt;
    logic             issue;

    // The requester keeps cmd_vld high while waiting for read data; mask it so no second read goes out.
    assign issue         = cmd_vld && !rd_pend;
    assign av_chipselect = issue;
    assign av_write_n    = !(issue && cmd_wr);
    assign av_read_n     = !(issue && !cmd_wr);
    assign av_address    = issue ? cmd_addr : '0;
    assign av_writedata  = (issue && cmd_wr) ? cmd_dat : '0;
    assign cmd_acc       = issue && !av_waitrequest;

    assign rd_vld = rd_pend && (rd_cnt == CNT_W'(1));
    assign rd_dat = av_readdata;
    assign busy   = issue || rd_pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend <= 1'b0;
            rd_cnt  <= '0;
        end else if (cmd_acc && !cmd_wr) begin
            rd_pend <= 1'b1;
            rd_cnt  <= CNT_W'(READ_LATENCY);
        end else if (rd_pend) begin
            if (rd_cnt == CNT_W'(1)) begin
                rd_pend <= 1'b0;
            end else begin
                rd_cnt <= rd_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/timer_irq_master.sv
// Timer master: configures, services and stops an Avalon-MM timer; snapshot path under TIMER_IRQ_MASTER_SNAP_EN.
// Latency: command on the bus the cycle after its trigger; tick/snap_valid one cycle after acceptance/capture.
// Backpressure: every command held under av_waitrequest; the FSM advances only on acceptance.
module timer_irq_master
    import timer_irq_master_pkg::*;
#(
    parameter int ADDR_W       = 3,
    parameter int DATA_W       = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              snap_req,
    input  logic              timer_irq,
    output logic [ADDR_W-1:0] av_address,
    output logic              av_chipselect,
    output logic              av_write_n,
    output logic              av_read_n,
    output logic [DATA_W-1:0] av_writedata,
    input  logic [DATA_W-1:0] av_readdata,
    input  logic              av_waitrequest,
    output logic              tick,
    output logic [31:0]       tick_count,
    output logic              running,
    output logic              snap_valid,
    output logic [31:0]       snap_value,
    output logic              busy
);

    state_t            state, state_next;
    logic              cmd_vld, cmd_wr, cmd_acc, rd_vld;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_dat, rd_dat;

`ifdef TIMER_IRQ_MASTER_SNAP_EN
    logic              snap_pend;
    logic [DATA_W-1:0] snap_l, snap_h;
`endif

    avmm_cmd_issuer #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_issuer (
        .clk            (clk),
        .reset          (reset),
        .cmd_vld        (cmd_vld),
        .cmd_wr         (cmd_wr),
        .cmd_addr       (cmd_addr),
        .cmd_dat        (cmd_dat),
        .cmd_acc        (cmd_acc),
        .rd_vld         (rd_vld),
        .rd_dat         (rd_dat),
        .busy           (busy),
        .av_address     (av_address),
        .av_chipselect  (av_chipselect),
        .av_write_n     (av_write_n),
        .av_read_n      (av_read_n),
        .av_writedata   (av_writedata),
        .av_readdata    (av_readdata),
        .av_waitrequest (av_waitrequest)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (enable) state_next = CFG_WR;
            CFG_WR:   if (cmd_acc) state_next = RUN;
            RUN: begin
                if (timer_irq) begin
                    state_next = CLR_WR;
                end else if (!enable) begin
                    state_next = STOP_WR;
                end
`ifdef TIMER_IRQ_MASTER_SNAP_EN
                else if (snap_pend) begin
                    state_next = SNAP_WR;
                end
`endif
            end
            CLR_WR:   if (cmd_acc) state_next = CLR_WAIT;
            // Gives the slave a cycle to drop its irq after the status clear.
            CLR_WAIT: state_next = RUN;
            STOP_WR:  if (cmd_acc) state_next = IDLE;
`ifdef TIMER_IRQ_MASTER_SNAP_EN
            SNAP_WR:  if (cmd_acc) state_next = SNAP_RDL;
            SNAP_RDL: if (rd_vld) state_next = SNAP_RDH;
            SNAP_RDH: if (rd_vld) state_next = RUN;
`endif
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_vld  = 1'b0;
        cmd_wr   = 1'b1;
        cmd_addr = '0;
        cmd_dat  = '0;
        running  = 1'b0;
        case (state)
            CFG_WR: begin
                cmd_vld  = 1'b1;
                cmd_addr = ADDR_W'(REG_CONTROL);
                cmd_dat  = DATA_W'(CTRL_START);
            end
            RUN, CLR_WAIT: running = 1'b1;
            CLR_WR: begin
                running  = 1'b1;
                cmd_vld  = 1'b1;
                cmd_addr = ADDR_W'(REG_STATUS);
            end
            STOP_WR: begin
                cmd_vld  = 1'b1;
                cmd_addr = ADDR_W'(REG_CONTROL);
                cmd_dat  = DATA_W'(CTRL_STOP);
            end
`ifdef TIMER_IRQ_MASTER_SNAP_EN
            SNAP_WR: begin
                running  = 1'b1;
                cmd_vld  = 1'b1;
                cmd_addr = ADDR_W'(REG_SNAP_L);
            end
            SNAP_RDL: begin
                running  = 1'b1;
                cmd_vld  = 1'b1;
                cmd_wr   = 1'b0;
                cmd_addr = ADDR_W'(REG_SNAP_L);
            end
            SNAP_RDH: begin
                running  = 1'b1;
                cmd_vld  = 1'b1;
                cmd_wr   = 1'b0;
                cmd_addr = ADDR_W'(REG_SNAP_H);
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick       <= 1'b0;
            tick_count <= '0;
        end else begin
            tick <= (state == CLR_WR) && cmd_acc;
            if ((state == CLR_WR) && cmd_acc) begin
                tick_count <= tick_count + 32'd1;
            end
        end
    end

`ifdef TIMER_IRQ_MASTER_SNAP_EN
    // Completion clears the pending flag even if snap_req fires that cycle, so overlapping requests merge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_pend  <= 1'b0;
            snap_l     <= '0;
            snap_h     <= '0;
            snap_valid <= 1'b0;
        end else begin
            snap_valid <= (state == SNAP_RDH) && rd_vld;
            if ((state == SNAP_RDL) && rd_vld) begin
                snap_l <= rd_dat;
            end
            if ((state == SNAP_RDH) && rd_vld) begin
                snap_h    <= rd_dat;
                snap_pend <= 1'b0;
            end else if (snap_req) begin
                snap_pend <= 1'b1;
            end
        end
    end

    assign snap_value = 32'({snap_h, snap_l});
`else
    logic unused_snap;
    assign unused_snap = ^{snap_req, rd_vld, rd_dat};
    assign snap_valid  = 1'b0;
    assign snap_value  = '0;
`endif

endmodule

// File: tb/tb_timer_irq_master.sv
// Directed bench for timer_irq_master with READ_LATENCY=2; snapshot scenarios follow TIMER_IRQ_MASTER_SNAP_EN.
module tb_timer_irq_master;

    localparam int ADDR_W       = 3;
    localparam int DATA_W       = 16;
    localparam int READ_LATENCY = 2;

    // {chipselect, write_n, read_n, address[2:0], writedata[15:0]}
    localparam logic [21:0] BUS_IDLE   = {1'b0, 1'b1, 1'b1, 3'd0, 16'h0000};
    localparam logic [21:0] BUS_CFG    = {1'b1, 1'b0, 1'b1, 3'd1, 16'h0007};
    localparam logic [21:0] BUS_CLR    = {1'b1, 1'b0, 1'b1, 3'd0, 16'h0000};
    localparam logic [21:0] BUS_STOP   = {1'b1, 1'b0, 1'b1, 3'd1, 16'h0008};
    localparam logic [21:0] BUS_SNAPWR = {1'b1, 1'b0, 1'b1, 3'd4, 16'h0000};
    localparam logic [21:0] BUS_RDL    = {1'b1, 1'b1, 1'b0, 3'd4, 16'h0000};
    localparam logic [21:0] BUS_RDH    = {1'b1, 1'b1, 1'b0, 3'd5, 16'h0000};

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic              snap_req = 1'b0;
    logic              timer_irq = 1'b0;
    logic              av_waitrequest = 1'b0;
    logic [DATA_W-1:0] av_readdata = 16'hBEEF;
    logic [ADDR_W-1:0] av_address;
    logic              av_chipselect, av_write_n, av_read_n;
    logic [DATA_W-1:0] av_writedata;
    logic              tick, running, snap_valid, busy;
    logic [31:0]       tick_count, snap_value;

    int vec = 0;
    int miss = 0;
    int wr_acc = 0;
    int rd_acc = 0;
    int sv_cnt = 0;

    wire [21:0] bus = {av_chipselect, av_write_n, av_read_n, av_address, av_writedata};

    always #5 clk = ~clk;

    timer_irq_master #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .READ_LATENCY (READ_LATENCY)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .snap_req       (snap_req),
        .timer_irq      (timer_irq),
        .av_address     (av_address),
        .av_chipselect  (av_chipselect),
        .av_write_n     (av_write_n),
        .av_read_n      (av_read_n),
        .av_writedata   (av_writedata),
        .av_readdata    (av_readdata),
        .av_waitrequest (av_waitrequest),
        .tick           (tick),
        .tick_count     (tick_count),
        .running        (running),
        .snap_valid     (snap_valid),
        .snap_value     (snap_value),
        .busy           (busy)
    );

    // Slave-side view: accepted commands and snapshot pulses.
    always @(posedge clk) begin
        if (av_chipselect && !av_waitrequest) begin
            if (!av_write_n) wr_acc++;
            if (!av_read_n) rd_acc++;
        end
        if (snap_valid) sv_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        vec++; if (bus !== BUS_IDLE) begin miss++; $display("FAIL reset_bus: got %h want %h", bus, BUS_IDLE); end
        vec++; if ({tick, running, snap_valid, busy} !== 4'b0000) begin miss++; $display("FAIL reset_flags: got %b want 0000", {tick, running, snap_valid, busy}); end
        vec++; if (tick_count !== 32'd0) begin miss++; $display("FAIL reset_tick_count: got %h want 0", tick_count); end
        vec++; if (snap_value !== 32'd0) begin miss++; $display("FAIL reset_snap_value: got %h want 0", snap_value); end
    endtask

    task automatic test_cfg_write();
        int w0;
        w0 = wr_acc;
        reset = 1'b0;
        enable = 1'b1;
        av_waitrequest = 1'b0;
        step();
        vec++; if (bus !== BUS_CFG) begin miss++; $display("FAIL cfg_cmd: got %h want %h", bus, BUS_CFG); end
        vec++; if ({busy, running} !== 2'b10) begin miss++; $display("FAIL cfg_busy_running: got %b want 10", {busy, running}); end
        step();
        vec++; if ({running, bus} !== {1'b1, BUS_IDLE}) begin miss++; $display("FAIL cfg_run: got %h want %h", {running, bus}, {1'b1, BUS_IDLE}); end
        vec++; if (wr_acc - w0 !== 1) begin miss++; $display("FAIL cfg_accept_count: got %0d want 1", wr_acc - w0); end
    endtask

    task automatic test_waitrequest();
        int w0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        enable = 1'b1;
        av_waitrequest = 1'b1;
        w0 = wr_acc;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 3) av_waitrequest = 1'b0;
            vec++; if (bus !== BUS_CFG) begin miss++; $display("FAIL wait_hold_%0d: got %h want %h", i, bus, BUS_CFG); end
        end
        step();
        vec++; if (wr_acc - w0 !== 1) begin miss++; $display("FAIL wait_accept_count: got %0d want 1", wr_acc - w0); end
        vec++; if (running !== 1'b1) begin miss++; $display("FAIL wait_running: got %b want 1", running); end
    endtask

    task automatic test_irq_tick();
        timer_irq = 1'b1;
        step();
        vec++; if (bus !== BUS_CLR) begin miss++; $display("FAIL irq_clr_cmd: got %h want %h", bus, BUS_CLR); end
        step();
        timer_irq = 1'b0;
        vec++; if ({tick, tick_count} !== {1'b1, 32'd1}) begin miss++; $display("FAIL irq_tick: got %h want %h", {tick, tick_count}, {1'b1, 32'd1}); end
        step();
        vec++; if ({tick, running} !== 2'b01) begin miss++; $display("FAIL irq_tick_end: got %b want 01", {tick, running}); end
        step();
        step();
        vec++; if (tick_count !== 32'd1) begin miss++; $display("FAIL irq_single_tick: got %h want 1", tick_count); end
    endtask

    task automatic test_back_to_back();
        timer_irq = 1'b1;
        step();
        step();
        vec++; if ({tick, tick_count} !== {1'b1, 32'd2}) begin miss++; $display("FAIL b2b_first: got %h want %h", {tick, tick_count}, {1'b1, 32'd2}); end
        step();
        step();
        timer_irq = 1'b0;
        av_waitrequest = 1'b1;
        vec++; if (bus !== BUS_CLR) begin miss++; $display("FAIL b2b_second_cmd: got %h want %h", bus, BUS_CLR); end
        step();
        av_waitrequest = 1'b0;
        vec++; if ({tick, tick_count, bus} !== {1'b0, 32'd2, BUS_CLR}) begin miss++; $display("FAIL b2b_stalled: got %h want %h", {tick, tick_count, bus}, {1'b0, 32'd2, BUS_CLR}); end
        step();
        vec++; if ({tick, tick_count} !== {1'b1, 32'd3}) begin miss++; $display("FAIL b2b_second: got %h want %h", {tick, tick_count}, {1'b1, 32'd3}); end
        step();
    endtask

`ifdef TIMER_IRQ_MASTER_SNAP_EN
    task automatic test_snapshot();
        int s0, r0;
        s0 = sv_cnt;
        r0 = rd_acc;
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        vec++; if ({running, bus} !== {1'b1, BUS_IDLE}) begin miss++; $display("FAIL snap_pending: got %h want %h", {running, bus}, {1'b1, BUS_IDLE}); end
        step();
        vec++; if (bus !== BUS_SNAPWR) begin miss++; $display("FAIL snap_wr: got %h want %h", bus, BUS_SNAPWR); end
        step();
        vec++; if (bus !== BUS_RDL) begin miss++; $display("FAIL snap_rdl: got %h want %h", bus, BUS_RDL); end
        step();
        snap_req = 1'b1;
        vec++; if ({bus, busy} !== {BUS_IDLE, 1'b1}) begin miss++; $display("FAIL snap_rd_wait: got %h want %h", {bus, busy}, {BUS_IDLE, 1'b1}); end
        step();
        snap_req = 1'b0;
        av_readdata = 16'h1234;
        step();
        av_readdata = 16'hBEEF;
        vec++; if (bus !== BUS_RDH) begin miss++; $display("FAIL snap_rdh: got %h want %h", bus, BUS_RDH); end
        step();
        step();
        av_readdata = 16'h0000;
        step();
        av_readdata = 16'hBEEF;
        vec++; if ({snap_valid, snap_value} !== {1'b1, 32'h0000_1234}) begin miss++; $display("FAIL snap_value: got %h want %h", {snap_valid, snap_value}, {1'b1, 32'h0000_1234}); end
        for (int i = 0; i < 6; i++) step();
        vec++; if (sv_cnt - s0 !== 1) begin miss++; $display("FAIL snap_single_valid: got %0d want 1", sv_cnt - s0); end
        vec++; if (rd_acc - r0 !== 2) begin miss++; $display("FAIL snap_read_count: got %0d want 2", rd_acc - r0); end
    endtask

    task automatic test_irq_during_snap();
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        step();
        step();
        timer_irq = 1'b1;
        vec++; if (bus !== BUS_RDL) begin miss++; $display("FAIL irqsnap_rdl: got %h want %h", bus, BUS_RDL); end
        step();
        step();
        av_readdata = 16'h00AB;
        step();
        av_readdata = 16'hBEEF;
        step();
        step();
        av_readdata = 16'h0001;
        step();
        av_readdata = 16'hBEEF;
        vec++; if ({snap_valid, snap_value, tick_count} !== {1'b1, 32'h0001_00AB, 32'd3}) begin miss++; $display("FAIL irqsnap_done: got %h want %h", {snap_valid, snap_value, tick_count}, {1'b1, 32'h0001_00AB, 32'd3}); end
        step();
        timer_irq = 1'b0;
        vec++; if (bus !== BUS_CLR) begin miss++; $display("FAIL irqsnap_clr: got %h want %h", bus, BUS_CLR); end
        step();
        vec++; if ({tick, tick_count} !== {1'b1, 32'd4}) begin miss++; $display("FAIL irqsnap_tick: got %h want %h", {tick, tick_count}, {1'b1, 32'd4}); end
        step();
    endtask
`else
    task automatic test_snap_ignored();
        int w0, r0;
        w0 = wr_acc;
        r0 = rd_acc;
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        for (int i = 0; i < 6; i++) step();
        vec++; if ((wr_acc - w0) + (rd_acc - r0) !== 0) begin miss++; $display("FAIL snapoff_no_cmd: got %0d want 0", (wr_acc - w0) + (rd_acc - r0)); end
        vec++; if ({sv_cnt, snap_value} !== {32'd0, 32'd0}) begin miss++; $display("FAIL snapoff_outputs: got %h want 0", {sv_cnt, snap_value}); end
    endtask
`endif

    task automatic test_stop();
        int w0;
        w0 = wr_acc;
        enable = 1'b0;
        av_waitrequest = 1'b0;
        step();
        vec++; if (bus !== BUS_STOP) begin miss++; $display("FAIL stop_cmd: got %h want %h", bus, BUS_STOP); end
        step();
        vec++; if ({running, bus} !== {1'b0, BUS_IDLE}) begin miss++; $display("FAIL stop_idle: got %h want %h", {running, bus}, {1'b0, BUS_IDLE}); end
        vec++; if (wr_acc - w0 !== 1) begin miss++; $display("FAIL stop_accept_count: got %0d want 1", wr_acc - w0); end
        step();
        step();
        vec++; if (bus !== BUS_IDLE) begin miss++; $display("FAIL stop_stays_idle: got %h want %h", bus, BUS_IDLE); end
    endtask

    task automatic test_reset_mid_cmd();
        enable = 1'b1;
        step();
        step();
        enable = 1'b0;
        av_waitrequest = 1'b1;
        step();
        vec++; if (bus !== BUS_STOP) begin miss++; $display("FAIL rstmid_stop_cmd: got %h want %h", bus, BUS_STOP); end
        reset = 1'b1;
        #1;
        vec++; if ({bus, busy, running} !== {BUS_IDLE, 1'b0, 1'b0}) begin miss++; $display("FAIL rstmid_bus_idle: got %h want %h", {bus, busy, running}, {BUS_IDLE, 1'b0, 1'b0}); end
        vec++; if (tick_count !== 32'd0) begin miss++; $display("FAIL rstmid_tick_count: got %h want 0", tick_count); end
        step();
        reset = 1'b0;
        av_waitrequest = 1'b0;
        step();
        step();
        vec++; if (bus !== BUS_IDLE) begin miss++; $display("FAIL rstmid_no_reissue: got %h want %h", bus, BUS_IDLE); end
        enable = 1'b1;
        step();
        vec++; if (bus !== BUS_CFG) begin miss++; $display("FAIL rstmid_restart_cfg: got %h want %h", bus, BUS_CFG); end
        step();
    endtask

    initial begin
        test_reset();
        test_cfg_write();
        test_waitrequest();
        test_irq_tick();
        test_back_to_back();
`ifdef TIMER_IRQ_MASTER_SNAP_EN
        test_snapshot();
        test_irq_during_snap();
`else
        test_snap_ignored();
`endif
        test_stop();
        test_reset_mid_cmd();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
